// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: access sizes, fault codes,
// controller states and the byte-lane helpers used when building a memory request.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      EXC_OK      = 2'd0,
      EXC_ALIGN   = 2'd1,
      EXC_RANGE   = 2'd2,
      EXC_TIMEOUT = 2'd3
   } exc_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Byte enables for an access of the given size at byte offset ofs within the word.
   function automatic logic [3:0] gen_be(input size_e size, input logic [1:0] ofs);
      case (size)
         SZ_BYTE: gen_be = 4'b0001 << ofs;
         SZ_HALF: gen_be = ofs[1] ? 4'b1100 : 4'b0011;
         default: gen_be = 4'b1111;
      endcase
   endfunction

   // Replicate right-justified store data across every lane so the enabled lane
   // always carries the right bytes regardless of offset.
   function automatic logic [31:0] gen_wdata(input size_e size, input logic [31:0] data);
      case (size)
         SZ_BYTE: gen_wdata = {4{data[7:0]}};
         SZ_HALF: gen_wdata = {2{data[15:0]}};
         default: gen_wdata = data;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load data extraction: picks the addressed byte/half out of the read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module mem_access_unit_load_ext
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  ofs,
   input  size_e       size,
   input  logic        sgn,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Lane select followed by extension according to size and signedness.
   always_comb begin
      byte_lane = rdata[8*ofs +: 8];
      half_lane = ofs[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: data = {{24{sgn & byte_lane[7]}}, byte_lane};
         SZ_HALF: data = {{16{sgn & half_lane[15]}}, half_lane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the CPU data-memory port. Accepts one load/store from the MEM
// stage, screens it for alignment and range, runs a req/ack transfer to data memory
// with an optional timeout, and reports extended load data or a fault code.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned DM_WORDS = 1024,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_valid,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_signed,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [31:0] cpu_pc,
   output logic        cpu_ready,
   output logic        cpu_done,
   output logic [31:0] cpu_rdata,
   output logic [1:0]  cpu_exc,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   state_e      state_reg, state_next;
   logic        we_reg;
   size_e       size_reg;
   logic        sgn_reg;
   logic [31:0] addr_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic [31:0] cnt_reg;
   logic [31:0] rdata_reg;
   exc_e        exc_reg;

   size_e       req_size;
   exc_e        fault_code;
   logic        timeout_hit;
   logic [31:0] ext_data;

   // The store PC only feeds off-chip trace; nothing in this block consumes it.
   logic [31:0] pc_unused;
   assign pc_unused = cpu_pc;

   assign req_size = size_e'(cpu_size);

   // Screen the incoming request: alignment (incl. illegal size) outranks range.
   always_comb begin
      fault_code = EXC_OK;
      if (req_size == SZ_ILL ||
          (req_size == SZ_HALF && cpu_addr[0]) ||
          (req_size == SZ_WORD && cpu_addr[1:0] != 2'b00))
         fault_code = EXC_ALIGN;
      else if ({2'b00, cpu_addr[31:2]} >= DM_WORDS)
         fault_code = EXC_RANGE;
   end

   // This REQ cycle is the last one allowed without an ack; TIMEOUT=0 disables.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TIMEOUT - 1);

   mem_access_unit_load_ext u_load_ext (
      .rdata (mem_rdata),
      .ofs   (addr_reg[1:0]),
      .size  (size_reg),
      .sgn   (sgn_reg),
      .data  (ext_data)
   );

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state: faults skip the memory, ack beats a coincident timeout.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (cpu_valid) state_next = (fault_code != EXC_OK) ? ST_DONE : ST_REQ;
         ST_REQ:  if (mem_ack || timeout_hit) state_next = ST_DONE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Request latch, wait counter and result capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_reg    <= 1'b0;
         size_reg  <= SZ_BYTE;
         sgn_reg   <= 1'b0;
         addr_reg  <= '0;
         be_reg    <= '0;
         wdata_reg <= '0;
         cnt_reg   <= '0;
         rdata_reg <= '0;
         exc_reg   <= EXC_OK;
      end else begin
         case (state_reg)
            ST_IDLE: if (cpu_valid) begin
               we_reg    <= cpu_we;
               size_reg  <= req_size;
               sgn_reg   <= cpu_signed;
               addr_reg  <= cpu_addr;
               be_reg    <= gen_be(req_size, cpu_addr[1:0]);
               wdata_reg <= gen_wdata(req_size, cpu_wdata);
               cnt_reg   <= '0;
               rdata_reg <= '0;
               exc_reg   <= fault_code;
            end
            ST_REQ: begin
               if (mem_ack) begin
                  rdata_reg <= we_reg ? 32'd0 : ext_data;
               end else begin
                  cnt_reg <= cnt_reg + 32'd1;
                  if (timeout_hit) exc_reg <= EXC_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode registered state only; bus fields read zero outside REQ.
   always_comb begin
      cpu_ready = (state_reg == ST_IDLE);
      cpu_done  = (state_reg == ST_DONE);
      cpu_rdata = (state_reg == ST_DONE) ? rdata_reg : 32'd0;
      cpu_exc   = (state_reg == ST_DONE) ? exc_reg : EXC_OK;
      mem_req   = (state_reg == ST_REQ);
      mem_we    = (state_reg == ST_REQ) && we_reg;
      mem_be    = (state_reg == ST_REQ) ? be_reg : 4'b0000;
      mem_addr  = (state_reg == ST_REQ) ? {addr_reg[31:2], 2'b00} : 32'd0;
      mem_wdata = (state_reg == ST_REQ && we_reg) ? wdata_reg : 32'd0;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written corner sequences
// (reset mid-transfer, request during DONE) and randomized transactions checked
// against an arithmetic model of the access rules.
module tb_mem_access_unit;

   localparam int unsigned TO  = 4;
   localparam int unsigned DMW = 1024;

   logic        clk;
   logic        reset;
   logic        cpu_valid, cpu_we, cpu_signed;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr, cpu_wdata, cpu_pc;
   logic        cpu_ready, cpu_done;
   logic [31:0] cpu_rdata;
   logic [1:0]  cpu_exc;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   int checks   = 0;
   int failures = 0;

   mem_access_unit #(.DM_WORDS(DMW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_valid  (cpu_valid),
      .cpu_we     (cpu_we),
      .cpu_size   (cpu_size),
      .cpu_signed (cpu_signed),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_pc     (cpu_pc),
      .cpu_ready  (cpu_ready),
      .cpu_done   (cpu_done),
      .cpu_rdata  (cpu_rdata),
      .cpu_exc    (cpu_exc),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      int          d;       // REQ cycles without ack before the acking one
      logic [1:0]  exc;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] mwdata;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected results from the access rules, using plain arithmetic on the address.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      int unsigned ofs;
      logic [31:0] lane;
      r   = v;
      ofs = v.addr % 4;
      r.maddr = v.addr - ofs;
      if (v.size == 2'd3 || (v.size == 2'd1 && ofs % 2 != 0) || (v.size == 2'd2 && ofs != 0))
         r.exc = 2'd1;
      else if (v.addr / 4 >= DMW)
         r.exc = 2'd2;
      else if (v.d >= int'(TO))
         r.exc = 2'd3;
      else
         r.exc = 2'd0;
      case (v.size)
         2'd0:    begin r.be = 4'(1 << ofs); r.mwdata = (v.wdata % 256) * 32'h0101_0101; end
         2'd1:    begin r.be = 4'(3 << ofs); r.mwdata = (v.wdata % 65536) * 32'h0001_0001; end
         default: begin r.be = 4'hF; r.mwdata = v.wdata; end
      endcase
      r.rdata = 32'd0;
      if (r.exc == 2'd0 && !v.we) begin
         case (v.size)
            2'd0: begin
               lane = (v.mrdata >> (8 * ofs)) % 256;
               if (v.sgn && lane >= 128) lane = lane - 32'd256;
            end
            2'd1: begin
               lane = (v.mrdata >> (8 * ofs)) % 65536;
               if (v.sgn && lane >= 32768) lane = lane - 32'd65536;
            end
            default: lane = v.mrdata;
         endcase
         r.rdata = lane;
      end
      return r;
   endfunction

   // One complete transaction with an acking memory; checks bus fields, result and timing.
   task automatic run_txn(input vec_t v, input logic [31:0] pc);
      int done_k, reqs, exp_k, exp_reqs;
      done_k = 0;
      reqs   = 0;
      if (v.exc == 2'd1 || v.exc == 2'd2) begin exp_k = 1; exp_reqs = 0; end
      else if (v.exc == 2'd3)              begin exp_k = int'(TO) + 1; exp_reqs = int'(TO); end
      else                                 begin exp_k = v.d + 2; exp_reqs = v.d + 1; end

      @(negedge clk);
      chk("ready_before", {31'd0, cpu_ready}, 32'd1);
      cpu_valid = 1'b1; cpu_we = v.we; cpu_size = v.size; cpu_signed = v.sgn;
      cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_pc = pc;
      @(posedge clk); #1;
      // scramble inputs to prove the request was latched
      cpu_valid = 1'b0; cpu_we = 1'($urandom); cpu_size = 2'($urandom);
      cpu_signed = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;

      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (cpu_done) begin
            done_k = k;
            chk("cpu_exc", {30'd0, cpu_exc}, {30'd0, v.exc});
            chk("cpu_rdata", cpu_rdata, v.rdata);
            chk("ready_in_done", {31'd0, cpu_ready}, 32'd0);
            break;
         end
         if (mem_req) begin
            chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
            chk("mem_addr", mem_addr, v.maddr);
            chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
            if (v.we) chk("mem_wdata", mem_wdata, v.mwdata);
            mem_ack   = (reqs == v.d);
            mem_rdata = mem_ack ? v.mrdata : $urandom;
            if (mem_ack && v.we)
               $display("@%h: *%h <= %h", pc, mem_addr,
                        mem_wdata & {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}});
            reqs++;
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      chk("done_latency", done_k, exp_k);
      chk("req_cycles", reqs, exp_reqs);
      @(negedge clk);
      chk("done_pulse_end", {31'd0, cpu_done}, 32'd0);
      chk("ready_after", {31'd0, cpu_ready}, 32'd1);
      $display("txn we=%0d size=%0d sgn=%0d addr=%h d=%0d -> exc=%0d rdata=%h latency=%0d",
               v.we, v.size, v.sgn, v.addr, v.d, v.exc, v.rdata, done_k);
   endtask

   vec_t tbl[13];
   vec_t rv;

   initial begin
      //           we    size  sgn   addr          wdata         mrdata        d   exc   rdata         be       maddr         mwdata
      tbl[0]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0,        32'h80FF_0102, 0, 2'd0, 32'hFFFF_FF80, 4'b1000, 32'h0000_0000, 32'h0};
      tbl[1]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h1234_ABCD, 32'h0,        1, 2'd0, 32'h0,        4'b1100, 32'h0000_0010, 32'hABCD_ABCD};
      tbl[2]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,        32'h1,         0, 2'd1, 32'h0,        4'b1111, 32'h0000_0004, 32'h0};
      tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_1000, 32'h0,        32'h1,         0, 2'd2, 32'h0,        4'b0011, 32'h0000_1000, 32'h0};
      tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,        32'h1122_3344, 10, 2'd3, 32'h0,       4'b1111, 32'h0000_0020, 32'h0};
      tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0024, 32'h0,        32'hDEAD_BEEF, 3, 2'd0, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0024, 32'h0};
      tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0,        32'h8001_0000, 0, 2'd0, 32'h0000_8001, 4'b1100, 32'h0000_0000, 32'h0};
      tbl[7]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0008, 32'h0,        32'h0,         0, 2'd1, 32'h0,        4'b1111, 32'h0000_0008, 32'h0};
      tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,        32'hFEDC_1234, 2, 2'd0, 32'hFFFF_FEDC, 4'b1100, 32'h0000_0100, 32'h0};
      tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0FFD, 32'h0000_00A5, 32'h0,        0, 2'd0, 32'h0,        4'b0010, 32'h0000_0FFC, 32'hA5A5_A5A5};
      tbl[10] = '{1'b0, 2'd0, 1'b0, 32'h0000_0401, 32'h0,        32'h0000_9900, 1, 2'd0, 32'h0000_0099, 4'b0010, 32'h0000_0400, 32'h0};
      tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0,        32'h0,         0, 2'd1, 32'h0,        4'b0011, 32'h0000_1000, 32'h0};
      tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h0000_0FF8, 32'hCAFE_F00D, 32'h0,        2, 2'd0, 32'h0,        4'b1111, 32'h0000_0FF8, 32'hCAFE_F00D};

      reset = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0; cpu_signed = 1'b0;
      cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_pc = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
      chk("rst_done", {31'd0, cpu_done}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_exc", {30'd0, cpu_exc}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_be", {28'd0, mem_be}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, cpu_ready}, 32'd1);

      // directed table
      for (int i = 0; i < 13; i++) run_txn(tbl[i], 32'h0000_0100 + 32'(4 * i));

      // request presented during DONE must be ignored
      @(negedge clk);
      cpu_valid = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_signed = 1'b0; cpu_addr = 32'h6;
      @(posedge clk); #1;
      cpu_size = 2'd1; cpu_addr = 32'h2;   // legal lhu held high through DONE
      @(negedge clk);
      chk("ign_done", {31'd0, cpu_done}, 32'd1);
      chk("ign_exc", {30'd0, cpu_exc}, 32'd1);
      @(negedge clk);
      chk("ign_done_drop", {31'd0, cpu_done}, 32'd0);
      chk("ign_ready", {31'd0, cpu_ready}, 32'd1);
      chk("ign_no_req", {31'd0, mem_req}, 32'd0);
      cpu_valid = 1'b0;
      @(negedge clk);
      chk("ign_still_idle", {31'd0, mem_req}, 32'd0);
      $display("txn request-during-DONE ignored sequence");

      // reset asserted while a request is outstanding
      @(negedge clk);
      cpu_valid = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h40;
      @(posedge clk); #1;
      cpu_valid = 1'b0;
      @(negedge clk);
      chk("rreq_req_high", {31'd0, mem_req}, 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("rreq_req_drop", {31'd0, mem_req}, 32'd0);
      chk("rreq_no_done", {31'd0, cpu_done}, 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rreq_idle_done", {31'd0, cpu_done}, 32'd0);
         chk("rreq_idle_ready", {31'd0, cpu_ready}, 32'd1);
      end
      $display("txn reset-during-REQ sequence");

      // randomized transactions against the model
      for (int i = 0; i < 40; i++) begin
         rv.we     = 1'($urandom);
         rv.size   = 2'($urandom_range(0, 3));
         rv.sgn    = 1'($urandom);
         rv.addr   = ($urandom_range(0, 7) == 0) ? 32'h0000_1000 + $urandom_range(0, 15)
                                                 : 32'($urandom_range(0, 4095));
         rv.wdata  = $urandom;
         rv.mrdata = $urandom;
         rv.d      = int'($urandom_range(0, 5));
         rv        = model(rv);
         run_txn(rv, $urandom & 32'hFFFF_FFFC);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
